// File: rtl/ftdi_pkg.sv
// Shared encodings for the FTDI receive path: SOF marker, error causes,
// and the state sets of the frame parser and its byte handshake.
package ftdi_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CKSUM   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN,
        S_PAYLOAD,
        S_CKSUM,
        S_DRAIN
    } main_state_e;

    typedef enum logic [1:0] {
        H_IDLE,
        H_ACK1,
        H_ACK2,
        H_WAITLOW
    } hs_state_e;

endpackage

// File: rtl/frame_buffer.sv
// Payload store: MAX_LEN bytes, one synchronous write port, combinational read.
module frame_buffer #(
    parameter int MAX_LEN = 16,
    parameter int AW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_idx_i,
    input  logic [7:0]    wr_dat_i,
    input  logic [AW-1:0] rd_idx_i,
    output logic [7:0]    rd_dat_o
);

    logic [7:0] mem_q [MAX_LEN];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_LEN; i++) begin
            if (wr_en_i && (wr_idx_i == AW'(i))) begin
                mem_q[i] <= wr_dat_i;
            end
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_idx_i == AW'(i)) begin
                rd_dat_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/rx_frame_parser.sv
// Assembles SOF/LEN/payload/CKSUM frames from the FTDI 4-phase byte handshake and
// releases good payloads on a valid/ready stream; input is stalled while draining.
module rx_frame_parser
    import ftdi_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    main_state_e   state_q, state_d;
    hs_state_e     hs_q, hs_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wr_idx_q, wr_idx_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    err_code_e     err_q, err_d;
    logic          ok_q, ok_d;

    logic          wr_en;
    logic          strobe;
    logic          timer_active;
    logic          expire;
    logic          xfer;
    logic [7:0]    buf_rd;
    logic [LW-1:0] wr_next;

    frame_buffer #(
        .MAX_LEN (MAX_LEN),
        .AW      (LW)
    ) u_buf (
        .clk_i    (clock_in),
        .wr_en_i  (wr_en),
        .wr_idx_i (wr_idx_q),
        .wr_dat_i (in_data),
        .rd_idx_i (rd_idx_q),
        .rd_dat_o (buf_rd)
    );

    assign in_ready     = (hs_q == H_ACK1) || (hs_q == H_ACK2);
    assign strobe       = (hs_q == H_ACK2);
    assign timer_active = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CKSUM);
    // An in-flight handshake defers expiry so its strobe can win.
    assign expire       = timer_active && !strobe && (hs_q != H_ACK1) &&
                          (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
    assign wr_next      = wr_idx_q + LW'(1);

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? buf_rd : '0;
    assign out_last  = out_valid && (rd_idx_q == (len_q - LW'(1)));
    assign xfer      = out_valid && out_ready;
    assign frame_ok  = ok_q || (xfer && out_last);
    assign frame_err = (err_q != ERR_NONE);
    assign err_code  = err_q;

    always_comb begin
        state_d  = state_q;
        hs_d     = hs_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        err_d    = ERR_NONE;
        ok_d     = 1'b0;
        wr_en    = 1'b0;

        unique case (hs_q)
            H_IDLE:    if (in_valid && (state_q != S_DRAIN)) hs_d = H_ACK1;
            H_ACK1:    hs_d = H_ACK2;
            H_ACK2:    hs_d = H_WAITLOW;
            H_WAITLOW: if (!in_valid) hs_d = H_IDLE;
            default:   hs_d = H_IDLE;
        endcase

        if (strobe || !timer_active) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (state_q == S_DRAIN) begin
            if (xfer) begin
                if (out_last) state_d = S_SYNC;
                else          rd_idx_d = rd_idx_q + LW'(1);
            end
        end else if (strobe) begin
            case (state_q)
                S_SYNC: if (in_data == SOF_BYTE) state_d = S_LEN;
                S_LEN: begin
                    sum_d    = in_data;
                    wr_idx_d = '0;
                    if (in_data > 8'(MAX_LEN)) begin
                        err_d   = ERR_LEN;
                        state_d = S_SYNC;
                    end else begin
                        len_d   = in_data[LW-1:0];
                        state_d = (in_data == 8'd0) ? S_CKSUM : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    wr_en    = 1'b1;
                    sum_d    = sum_q + in_data;
                    wr_idx_d = wr_next;
                    if (wr_next == len_q) state_d = S_CKSUM;
                end
                S_CKSUM: begin
                    state_d = S_SYNC;
                    if (in_data != sum_q) begin
                        err_d = ERR_CKSUM;
                    end else if (len_q != '0) begin
                        rd_idx_d = '0;
                        state_d  = S_DRAIN;
                    end else begin
                        ok_d = 1'b1;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end else if (expire) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_SYNC;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q  <= S_SYNC;
            hs_q     <= H_IDLE;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            err_q    <= ERR_NONE;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hs_q     <= hs_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ok_q     <= ok_d;
        end
    end

endmodule
